// File: rtl/mult_div_unit_if.sv
// Handshake and result bundle between the register-file read side
// and the iterative multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HiWrite;
  logic             LoWrite;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Op, A, B, HiWrite, LoWrite,
    input  Hi, Lo, Busy, Done
  );

  modport slave (
    input  Start, Op, A, B, HiWrite, LoWrite,
    output Hi, Lo, Busy, Done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO result
// registers and mthi/mtlo write access while idle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic Clk,
  input logic Rst_n,
  mult_div_unit_if.slave io
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               bz_q, bz_d;
  logic               done_q, done_d;

  logic             in_sgn;
  logic [WIDTH-1:0] in_ma;
  logic [WIDTH-1:0] in_mb;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH:0]   div_sub;
  logic             div_ok;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  assign in_sgn = ~io.Op[0];
  assign in_ma = (in_sgn && io.A[WIDTH-1]) ? -io.A : io.A;
  assign in_mb = (in_sgn && io.B[WIDTH-1]) ? -io.B : io.B;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, ma_q} : '0);

  // Shift-left view of the partial remainder, one bit wider
  assign rem_s = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_sub = rem_s - {1'b0, mb_q};
  assign div_ok = ~div_sub[WIDTH];

  assign quo = acc_q[WIDTH-1:0];
  assign rem = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.Start) begin
          op_d    = io.Op;
          a_d     = io.A;
          ma_d    = in_ma;
          mb_d    = in_mb;
          neg_d   = in_sgn & (io.A[WIDTH-1] ^ io.B[WIDTH-1]);
          rneg_d  = in_sgn & io.A[WIDTH-1];
          bz_d    = (io.B == '0);
          acc_d   = io.Op[1] ? {{WIDTH{1'b0}}, in_ma}
                             : {{WIDTH{1'b0}}, in_mb};
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          if (io.HiWrite) hi_d = io.A;
          if (io.LoWrite) lo_d = io.A;
        end
      end
      RUN: begin
        if (op_q[1]) begin
          acc_d = div_ok
            ? {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
            : {rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end else if (bz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          lo_d = neg_q ? -quo : quo;
          hi_d = rneg_q ? -rem : rem;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      done_q  <= done_d;
    end
  end

  assign io.Hi   = hi_q;
  assign io.Lo   = lo_q;
  assign io.Busy = (state_q != IDLE);
  assign io.Done = done_q;
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit directly downstream of the register file's two read ports; consumes ReadData1/ReadData2 as operands A/B.
Executes MULT, MULTU, DIV, DIVU over a fixed multi-cycle schedule and holds the 64-bit result in the HI/LO registers.
Hi and Lo are read by the write-back path (mfhi/mflo).
Direct HI/LO writes (mthi/mtlo) are supported when the unit is idle.

Parameters:
WIDTH, 32, operand width and width of each of Hi and Lo
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
Clk  input  1  system clock; all state updates on posedge
Rst_n  input  1  asynchronous, active-low reset
Start  input  1  launch operation; sampled on posedge only while idle
Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
A  input  WIDTH  operand rs (multiplicand / dividend)
B  input  WIDTH  operand rt (multiplier / divisor)
HiWrite  input  1  mthi strobe: Hi <= A
LoWrite  input  1  mtlo strobe: Lo <= A
Hi  output  WIDTH  HI register (product high word / remainder)
Lo  output  WIDTH  LO register (product low word / quotient)
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse after Hi/Lo update

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst_n is asynchronous and active-low.
- Reset: on Rst_n low, immediately force state IDLE, Hi=0, Lo=0, Busy=0, Done=0, counter=0, internal operand registers cleared. This applies in any state, including mid-operation; the aborted result is discarded.
- States and transitions:
  - IDLE: Busy=0. On a posedge with Start=1, capture Op, A and B, reduce signed operands to magnitudes, counter=0, go to RUN.
  - RUN: Busy=1. One radix-2 step per cycle, 32 cycles total (counter 0..31). Multiply uses shift-add on magnitudes. Divide uses restoring shift-subtract on magnitudes. After the counter=31 step, go to FIX.
  - FIX: Busy=1. Apply sign correction and write Hi/Lo on this edge. Done=1 for the following cycle. Return to IDLE.
- Latency: Start sampled at edge N, Hi/Lo updated at edge N+33, Done high during the cycle after edge N+33. Busy is high from edge N+1 through edge N+33 and low after edge N+33.
- Next start: a new Start may be accepted at edge N+34, the cycle Done is high.
- Operand capture: A and B are captured at the Start edge. Later changes to A, B or Op during RUN/FIX have no effect.
- Start while Busy: ignored entirely, with no queuing.
- Multiply width rules: {Hi,Lo} is the full 64-bit product. For MULT, the product sign is A[31]^B[31]; negate the 64-bit magnitude when set.
- Divide width rules:
  - Lo = quotient, Hi = remainder.
  - DIV: quotient sign = A[31]^B[31]; remainder sign = A[31].
  - Magnitudes are 32-bit unsigned, so -2^31 is handled as 0x80000000.
  - Overflow: DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0, with no exception.
- Divide by zero (B=0, DIV or DIVU): full latency still applies. Result is Lo=0xFFFFFFFF, Hi=A as captured (raw value, not magnitude).
- HiWrite/LoWrite:
  - Honoured only in IDLE with Start=0; Hi/Lo updated at that edge.
  - Ignored while Busy.
  - If Start=1 in the same IDLE cycle, Start wins and the writes are dropped.
- Done: never asserted for an aborted (reset) operation.
- Hi/Lo hold value: they hold their value in all cycles except the FIX edge and honoured HiWrite/LoWrite edges.

Test Plan:
- Reset then MULT, A=0xFFFFFFFD (-3), B=7, Start at edge 0 -> Busy edges 1..33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB at edge 33; Done pulse 1 cycle.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; then MULT with the same operands -> Hi=0, Lo=1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=100, B=7 -> Lo=14, Hi=2.
- DIV A=5, B=0 -> Lo=0xFFFFFFFF, Hi=5 after full latency; DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- During RUN, pulse Start with new operands plus HiWrite with A=0x1234 -> both ignored, original result delivered. In IDLE, HiWrite with A=0x1234 -> Hi=0x1234 next edge. In IDLE, Start=1 with LoWrite=1 -> LoWrite dropped.
- Rst_n low for 1 cycle at RUN cycle 10 -> Busy=0, Hi=Lo=0 immediately with no Done. After release, DIVU A=9, B=3 -> Lo=3, Hi=0 at start+33.
